intrude_host_if: RTL and testbench
==================================

Name: intrude_host_if

Overview:
- Host-side front end for the Slipstream intrude (host DMA) path.
- Accepts byte-wide commands from the host port over an asynchronous strobe/acknowledge handshake and holds a 20-bit intrude address.
- Issues one TRUDY/RD/WR request per host access to the downstream intrude DMA sequencer, then returns read data and an acknowledge to the host.
- Sits directly upstream of the intrude sequencer and drives its TRUDY, RD and WR inputs.

Parameters:
- ADDR_W, 20, intrude address width (1 MB space).
- DATA_W, 8, host and intrude data width.
- SYNC_STAGES, 2, flip-flop stages on HSTB; legal values 2..3.
- TIMEOUT, 255, REQ-state cycle limit before abort; legal values 1..255, fits an 8-bit counter.

Ports:
- CLK  in  1  system clock; single clock domain.
- RESETL  in  1  asynchronous active-low reset.
- HSTB  in  1  host strobe, asynchronous to CLK, level-held by the host until HACK.
- HCMD  in  3  host command, stable while HSTB is high.
- HDIN  in  DATA_W  host write data / address byte.
- HDOUT  out  DATA_W  read data returned to the host.
- HACK  out  1  host acknowledge.
- HERR  out  1  sticky timeout flag.
- TRUDY  out  1  intrude request to the sequencer.
- RD  out  1  intrude read qualifier.
- WR  out  1  intrude write qualifier.
- IADDR  out  ADDR_W  intrude address.
- IDOUT  out  DATA_W  intrude write data.
- IDIN  in  DATA_W  intrude read data.
- IDONE  in  1  single-cycle pulse from the sequencer: access complete.

Behaviour:
- Reset (asynchronous, RESETL low): state IDLE; HACK, HERR, TRUDY, RD, WR = 0; IADDR = 0; IDOUT = 0; HDOUT = 0; synchroniser cleared. Any in-flight access is abandoned with no acknowledge.
- HSTB passes through SYNC_STAGES flip-flops. A 0->1 edge on the synchronised strobe (hstb_rise) is the only command trigger.
- Commands (HCMD):
  - 0: load IADDR[7:0]
  - 1: load IADDR[15:8]
  - 2: load IADDR[19:16] from HDIN[3:0]; HDIN[7:4] ignored
  - 3: WRITE
  - 4: READ
  - 5: clear HERR
  - 6-7: no-op, still acknowledged
- States:
  - IDLE: on hstb_rise, sample HCMD/HDIN into registers and go to DECODE. No other trigger is accepted.
  - DECODE (1 cycle):
    - Address/clear/no-op commands update their register and go to ACK.
    - WRITE loads IDOUT and goes to REQ.
    - READ goes to REQ.
  - REQ: TRUDY = 1; WR = 1 for WRITE, RD = 1 for READ; never both. Timeout counter starts at 0 on entry.
    - On IDONE: drop TRUDY/RD/WR the next cycle; READ latches IDIN into HDOUT in the same edge; IADDR += 1 with wrap 0xFFFFF -> 0x00000; go to ACK.
    - If the counter reaches TIMEOUT with no IDONE: drop TRUDY/RD/WR, set HERR = 1, IADDR unchanged, HDOUT unchanged, go to ACK.
    - IDONE and timeout in the same cycle: IDONE wins.
  - ACK: HACK = 1. When the synchronised strobe is low, HACK = 0 and go to IDLE.
- IDONE outside REQ is ignored.
- HSTB toggling during REQ is ignored; its rising edge is re-detected only from IDLE.
- Latency, synchronised edge to TRUDY: 2 cycles (IDLE->DECODE->REQ).
- Latency, IDONE to HACK: 1 cycle.
- HERR is cleared only by command 5 or reset. Setting and clearing never coincide.

Decomposition:
- Shared package intrude_pkg holds:
  - the state enum (IDLE, DECODE, REQ, ACK)
  - the command constants CMD_ADDR_L, CMD_ADDR_M, CMD_ADDR_H, CMD_WRITE, CMD_READ, CMD_CLRERR
  - the ADDR_W/DATA_W defaults
- One sub-module, sync_edge: a SYNC_STAGES synchroniser plus rising-edge detector, reused for other asynchronous host inputs.

Test Plan:
- Reset mid-REQ: assert RESETL low while TRUDY = 1 -> all outputs 0 immediately (asynchronous), IADDR = 0; after release, state IDLE and no HACK.
- Address load then write: commands 0/1/2 with 0x34, 0x12, 0xF5 -> IADDR = 0x51234. WRITE 0xA5 -> TRUDY = WR = 1, RD = 0, IDOUT = 0xA5; IDONE after 3 cycles -> HACK next cycle, IADDR = 0x51235.
- Read: IDIN = 0x3C, IDONE pulse -> HDOUT = 0x3C, HACK = 1; HSTB low -> HACK = 0 after sync delay.
- Wrap: IADDR = 0xFFFFF, READ completes -> IADDR = 0x00000.
- Timeout: TIMEOUT = 4, WRITE with no IDONE -> TRUDY drops after 4 REQ cycles, HERR = 1, HACK = 1, IADDR unchanged; command 5 -> HERR = 0.
- Protocol noise: IDONE pulses while in IDLE and HSTB re-pulsed during REQ -> no state change and exactly one access issued.

Source files
------------

// File: rtl/intrude_pkg.sv
// Shared types and constants for the intrude host front end.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package intrude_pkg;

  localparam int ADDR_W_DEF = 20;
  localparam int DATA_W_DEF = 8;

  // Host access sequencing states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    REQ    = 2'd2,
    ACK    = 2'd3
  } state_t;

  // Host command encodings; 6 and 7 are acknowledged no-ops
  localparam logic [2:0] CMD_ADDR_L = 3'd0;
  localparam logic [2:0] CMD_ADDR_M = 3'd1;
  localparam logic [2:0] CMD_ADDR_H = 3'd2;
  localparam logic [2:0] CMD_WRITE  = 3'd3;
  localparam logic [2:0] CMD_READ   = 3'd4;
  localparam logic [2:0] CMD_CLRERR = 3'd5;

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchroniser for an asynchronous level input plus rising-edge detect.
// Latency: SYNC_STAGES cycles from input change to sync_out; rise is combinational on sync_out.
// Backpressure: none; rise is a one-cycle pulse that is lost if the consumer ignores it.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  // Shift the raw input through the chain and remember the last synchronised level
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Synchroniser and history registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise     = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/intrude_host_if.sv
// Host strobe/ack command front end issuing one TRUDY/RD/WR request per host access.
// Latency: synchronised strobe edge to TRUDY 2 cycles; IDONE to HACK 1 cycle.
// Backpressure: host holds HSTB until HACK; REQ waits for IDONE or aborts after TIMEOUT cycles.
module intrude_host_if
  import intrude_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic              CLK,
  input  logic              RESETL,
  input  logic              HSTB,
  input  logic [2:0]        HCMD,
  input  logic [DATA_W-1:0] HDIN,
  output logic [DATA_W-1:0] HDOUT,
  output logic              HACK,
  output logic              HERR,
  output logic              TRUDY,
  output logic              RD,
  output logic              WR,
  output logic [ADDR_W-1:0] IADDR,
  output logic [DATA_W-1:0] IDOUT,
  input  logic [DATA_W-1:0] IDIN,
  input  logic              IDONE
);

  // Last REQ cycle before the access is abandoned (counter starts at 0 on entry)
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [2:0]          cmd_q, cmd_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [ADDR_W-1:0]   iaddr_q, iaddr_d;
  logic [DATA_W-1:0]   idout_q, idout_d;
  logic [DATA_W-1:0]   hdout_q, hdout_d;
  logic                herr_q, herr_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                hstb_sync, hstb_rise;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_hstb_sync (
    .clk      (CLK),
    .rst_n    (RESETL),
    .async_in (HSTB),
    .sync_out (hstb_sync),
    .rise     (hstb_rise)
  );

  // Next-state and register update logic for one host access
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    din_d   = din_q;
    iaddr_d = iaddr_q;
    idout_d = idout_q;
    hdout_d = hdout_q;
    herr_d  = herr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        // Only a fresh strobe edge seen here starts an access
        if (hstb_rise) begin
          cmd_d   = HCMD;
          din_d   = HDIN;
          state_d = DECODE;
        end
      end
      DECODE: begin
        state_d = ACK;
        cnt_d   = '0;
        case (cmd_q)
          CMD_ADDR_L: iaddr_d[7:0]         = din_q;
          CMD_ADDR_M: iaddr_d[15:8]        = din_q;
          CMD_ADDR_H: iaddr_d[ADDR_W-1:16] = din_q[ADDR_W-17:0];
          CMD_WRITE: begin
            idout_d = din_q;
            state_d = REQ;
          end
          CMD_READ:   state_d = REQ;
          CMD_CLRERR: herr_d  = 1'b0;
          default: ;
        endcase
      end
      REQ: begin
        // Completion takes priority over a timeout landing on the same cycle
        if (IDONE) begin
          if (cmd_q == CMD_READ) hdout_d = IDIN;
          iaddr_d = iaddr_q + ADDR_W'(1);
          state_d = ACK;
        end else if (cnt_q == TMO_LAST) begin
          herr_d  = 1'b1;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ACK: begin
        if (!hstb_sync) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any access in flight
  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      din_q   <= '0;
      iaddr_q <= '0;
      idout_q <= '0;
      hdout_q <= '0;
      herr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      din_q   <= din_d;
      iaddr_q <= iaddr_d;
      idout_q <= idout_d;
      hdout_q <= hdout_d;
      herr_q  <= herr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign TRUDY = (state_q == REQ);
  assign WR    = TRUDY && (cmd_q == CMD_WRITE);
  assign RD    = TRUDY && (cmd_q == CMD_READ);
  assign HACK  = (state_q == ACK);
  assign HERR  = herr_q;
  assign IADDR = iaddr_q;
  assign IDOUT = idout_q;
  assign HDOUT = hdout_q;

endmodule

// File: tb/tb_intrude_host_if.sv
// Scoreboard bench for intrude_host_if: expectations queued by stimulus, checked by a monitor.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_intrude_host_if;

  logic        CLK;
  logic        RESETL;
  logic        HSTB;
  logic [2:0]  HCMD;
  logic [7:0]  HDIN;
  logic [7:0]  HDOUT;
  logic        HACK;
  logic        HERR;
  logic        TRUDY;
  logic        RD;
  logic        WR;
  logic [19:0] IADDR;
  logic [7:0]  IDOUT;
  logic [7:0]  IDIN;
  logic        IDONE;

  intrude_host_if #(
    .ADDR_W(20), .DATA_W(8), .SYNC_STAGES(2), .TIMEOUT(4)
  ) dut (
    .CLK(CLK), .RESETL(RESETL), .HSTB(HSTB), .HCMD(HCMD), .HDIN(HDIN),
    .HDOUT(HDOUT), .HACK(HACK), .HERR(HERR), .TRUDY(TRUDY), .RD(RD), .WR(WR),
    .IADDR(IADDR), .IDOUT(IDOUT), .IDIN(IDIN), .IDONE(IDONE)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [19:0] addr;
    logic [7:0]  dout;
    int          len;
  } req_exp_t;

  typedef struct {
    logic [7:0]  hdout;
    logic [19:0] addr;
    logic        herr;
    logic        via_idone;
  } ack_exp_t;

  req_exp_t req_q[$];
  ack_exp_t ack_q[$];

  int checks   = 0;
  int failures = 0;

  int         resp_delay = -1;
  logic [7:0] resp_idin  = 8'h00;
  int         noise_req  = 0;
  int         noise_done = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event-missing required=event-seen", name);
  endtask

  task automatic exp_req(input logic rd, input logic wr, input logic [19:0] a,
                         input logic [7:0] d, input int len);
    req_exp_t r;
    r.rd = rd; r.wr = wr; r.addr = a; r.dout = d; r.len = len;
    req_q.push_back(r);
  endtask

  task automatic exp_ack(input logic [7:0] hd, input logic [19:0] a,
                         input logic herr, input logic via);
    ack_exp_t e;
    e.hdout = hd; e.addr = a; e.herr = herr; e.via_idone = via;
    ack_q.push_back(e);
  endtask

  // One host access: raise strobe, optionally re-pulse it during REQ, wait for HACK, release
  task automatic host_op(input logic [2:0] cmd, input logic [7:0] din, input int dly,
                         input logic [7:0] idin, input bit noise);
    int k;
    resp_delay = dly;
    resp_idin  = idin;
    @(negedge CLK);
    HCMD = cmd;
    HDIN = din;
    HSTB = 1'b1;
    if (noise) begin
      k = 0;
      while (!TRUDY && k < 50) begin @(negedge CLK); k++; end
      HSTB = 1'b0;
      @(negedge CLK);
      HSTB = 1'b1;
    end
    k = 0;
    while (!HACK && k < 300) begin @(negedge CLK); k++; end
    if (!HACK) fail_now("hack_rise_wait");
    HSTB = 1'b0;
    k = 0;
    while (HACK && k < 50) begin @(negedge CLK); k++; end
    if (HACK) fail_now("hack_fall_wait");
    repeat (2) @(negedge CLK);
  endtask

  // Sequencer model: pulses IDONE after resp_delay REQ cycles, plus stray pulses on request
  initial begin
    int n;
    n = 0;
    IDONE = 1'b0;
    IDIN  = 8'h00;
    forever begin
      @(negedge CLK);
      IDONE = 1'b0;
      if (noise_req != noise_done) begin
        IDONE = 1'b1;
        IDIN  = 8'hEE;
        noise_done++;
      end else if (TRUDY) begin
        n++;
        if (resp_delay > 0 && n == resp_delay) begin
          IDONE = 1'b1;
          IDIN  = resp_idin;
        end
      end else begin
        n = 0;
      end
    end
  end

  // Monitor: pops an expectation on every request start, request end and acknowledge
  initial begin
    logic     trudy_prev, hack_prev;
    int       tlen, cur_len;
    req_exp_t r;
    ack_exp_t a;
    trudy_prev = 1'b0;
    hack_prev  = 1'b0;
    tlen       = 0;
    cur_len    = -1;
    forever begin
      @(posedge CLK);
      #1;
      if (TRUDY && !trudy_prev) begin
        if (req_q.size() == 0) begin
          fail_now("req_unexpected");
          cur_len = -1;
        end else begin
          r = req_q.pop_front();
          check("req_fields", 64'({RD, WR, IADDR, IDOUT}), 64'({r.rd, r.wr, r.addr, r.dout}));
          cur_len = r.len;
        end
      end
      if (TRUDY) tlen++;
      if (!TRUDY && trudy_prev) begin
        if (cur_len > 0) check("req_length", 64'(tlen), 64'(cur_len));
        tlen = 0;
      end
      if (HACK && !hack_prev) begin
        if (ack_q.size() == 0) begin
          fail_now("ack_unexpected");
        end else begin
          a = ack_q.pop_front();
          check("ack_fields", 64'({HDOUT, IADDR, HERR, IDONE}),
                64'({a.hdout, a.addr, a.herr, a.via_idone}));
        end
      end
      trudy_prev = TRUDY;
      hack_prev  = HACK;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog actual=still-running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    RESETL = 1'b0;
    HSTB   = 1'b0;
    HCMD   = 3'd0;
    HDIN   = 8'h00;
    #3;
    check("reset_outputs", 64'({HACK, HERR, TRUDY, RD, WR, IADDR, IDOUT, HDOUT}), 64'd0);
    repeat (3) @(negedge CLK);
    RESETL = 1'b1;
    repeat (2) @(negedge CLK);

    // Address load then write
    exp_ack(8'h00, 20'h00034, 1'b0, 1'b0); host_op(3'd0, 8'h34, -1, 8'h00, 1'b0);
    exp_ack(8'h00, 20'h01234, 1'b0, 1'b0); host_op(3'd1, 8'h12, -1, 8'h00, 1'b0);
    exp_ack(8'h00, 20'h51234, 1'b0, 1'b0); host_op(3'd2, 8'hF5, -1, 8'h00, 1'b0);
    exp_req(1'b0, 1'b1, 20'h51234, 8'hA5, 3);
    exp_ack(8'h00, 20'h51235, 1'b0, 1'b1); host_op(3'd3, 8'hA5, 3, 8'h00, 1'b0);

    // Read
    exp_req(1'b1, 1'b0, 20'h51235, 8'hA5, 2);
    exp_ack(8'h3C, 20'h51236, 1'b0, 1'b1); host_op(3'd4, 8'h00, 2, 8'h3C, 1'b0);

    // Address wrap on read completion; upper nibble of the high byte is ignored
    exp_ack(8'h3C, 20'h512FF, 1'b0, 1'b0); host_op(3'd0, 8'hFF, -1, 8'h00, 1'b0);
    exp_ack(8'h3C, 20'h5FFFF, 1'b0, 1'b0); host_op(3'd1, 8'hFF, -1, 8'h00, 1'b0);
    exp_ack(8'h3C, 20'hFFFFF, 1'b0, 1'b0); host_op(3'd2, 8'hFF, -1, 8'h00, 1'b0);
    exp_req(1'b1, 1'b0, 20'hFFFFF, 8'hA5, 1);
    exp_ack(8'h81, 20'h00000, 1'b0, 1'b1); host_op(3'd4, 8'h00, 1, 8'h81, 1'b0);

    // Timeout: no IDONE, abort after 4 REQ cycles, then clear the flag
    exp_req(1'b0, 1'b1, 20'h00000, 8'h5A, 4);
    exp_ack(8'h81, 20'h00000, 1'b1, 1'b0); host_op(3'd3, 8'h5A, -1, 8'h00, 1'b0);
    exp_ack(8'h81, 20'h00000, 1'b0, 1'b0); host_op(3'd5, 8'h00, -1, 8'h00, 1'b0);

    // IDONE on the same cycle the timeout would fire: completion wins
    exp_req(1'b1, 1'b0, 20'h00000, 8'h5A, 4);
    exp_ack(8'h77, 20'h00001, 1'b0, 1'b1); host_op(3'd4, 8'h00, 4, 8'h77, 1'b0);

    // Stray IDONE pulses while idle change nothing
    noise_req++;
    repeat (3) @(negedge CLK);
    noise_req++;
    repeat (3) @(negedge CLK);
    check("idle_idone_ignored", 64'({IADDR, HDOUT, HACK, TRUDY, HERR}),
          64'({20'h00001, 8'h77, 3'b000}));

    // Strobe re-pulsed during REQ: exactly one access, write does not touch HDOUT
    exp_req(1'b0, 1'b1, 20'h00001, 8'h11, 3);
    exp_ack(8'h77, 20'h00002, 1'b0, 1'b1); host_op(3'd3, 8'h11, 3, 8'hEE, 1'b1);

    // No-op commands are still acknowledged
    exp_ack(8'h77, 20'h00002, 1'b0, 1'b0); host_op(3'd6, 8'h42, -1, 8'h00, 1'b0);
    exp_ack(8'h77, 20'h00002, 1'b0, 1'b0); host_op(3'd7, 8'h24, -1, 8'h00, 1'b0);

    // Reset asserted mid-REQ: outputs clear immediately, no acknowledge afterwards
    resp_delay = -1;
    exp_req(1'b0, 1'b1, 20'h00002, 8'h99, -1);
    @(negedge CLK);
    HCMD = 3'd3;
    HDIN = 8'h99;
    HSTB = 1'b1;
    k = 0;
    while (!TRUDY && k < 50) begin @(negedge CLK); k++; end
    if (!TRUDY) fail_now("trudy_wait");
    #1;
    RESETL = 1'b0;
    #1;
    check("async_reset_outputs", 64'({HACK, HERR, TRUDY, RD, WR, IADDR, IDOUT, HDOUT}), 64'd0);
    HSTB = 1'b0;
    repeat (3) @(negedge CLK);
    RESETL = 1'b1;
    repeat (6) @(negedge CLK);
    check("post_reset_idle", 64'({HACK, TRUDY, IADDR}), 64'd0);

    check("queues_drained", 64'({32'(req_q.size()), 32'(ack_q.size())}), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
